// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues sequential word fetches over a
// valid/ready request channel, pairs in-order responses with their PC, and
// queues the instructions for the decode stage. A redirect flushes the queue,
// marks in-flight responses for discard and restarts at the new PC.
module fetch_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pcf    [QUEUE_DEPTH];  // PCs of accepted requests
  logic [PW-1:0]         head, tail, pcf_wr, pcf_rd;
  logic [CW-1:0]         count, outstanding, drop_cnt;
  logic [CW:0]           in_use;
  logic                  req_fire, rsp_fire, push, pop;
  logic                  unused_ok;

  // The low two redirect bits are ignored; the restart address is word aligned.
  assign unused_ok = ^redirect_pc[1:0];

  // Credit check: a request is only offered when its response is sure to fit.
  assign in_use         = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid &&
                          (in_use < (CW+1)'(QUEUE_DEPTH));
  assign imem_req_addr  = pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_fire = !rst && imem_rsp_valid && (outstanding != '0);
  assign push     = rsp_fire && (drop_cnt == '0) && !redirect_valid;
  assign pop      = instr_valid && instr_ready && !redirect_valid;

  // Decode-side outputs: queue head when non-empty, zeros (nop) otherwise.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    instr_valid = 1'b0;
    instr       = '0;
    instr_pc    = '0;
    if (!rst && (count != '0)) begin
      instr_valid = 1'b1;
      instr       = q_data[head];
      instr_pc    = q_pc[head];
    end
  end

  // Control state: PC, queue/PC-FIFO pointers and the in-flight counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      pc          <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      pcf_wr      <= '0;
      pcf_rd      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight is stale; count it off as it returns.
      pc          <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(rsp_fire);
      drop_cnt    <= outstanding - CW'(rsp_fire);
      if (rsp_fire) pcf_rd <= pcf_rd + PW'(1);
    end else begin
      if (req_fire) begin
        pc     <= pc + ADDR_WIDTH'(4);
        pcf_wr <= pcf_wr + PW'(1);
      end
      if (rsp_fire) begin
        pcf_rd <= pcf_rd + PW'(1);
        if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      count       <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage writes: request PCs into the PC FIFO, responses into the queue.
  always_ff @(posedge clk) begin
    // NOTE: the arrays are not reset; count and the pointers alone define which entries are live.
    if (req_fire) pcf[pcf_wr] <= pc;
    if (push) begin
      q_data[tail] <= imem_rsp_data;
      q_pc[tail]   <= pcf[pcf_rd];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each cycle the inputs are driven just after
// the rising edge, outputs are checked once they settle, and memory responses
// are supplied by hand with the latency each scenario calls for.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle.
  task automatic drive(input logic rq_rdy, input logic rs_v, input logic [31:0] rs_d,
                       input logic rd_v, input logic [31:0] rd_pc, input logic i_rdy);
    imem_req_ready = rq_rdy;
    imem_rsp_valid = rs_v;
    imem_rsp_data  = rs_d;
    redirect_valid = rd_v;
    redirect_pc    = rd_pc;
    instr_ready    = i_rdy;
    #1;
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1, 0, 0, 0, 0, 0);
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_instr", instr, 0);
    end

    // Streaming, 1-cycle memory
    tick(); rst = 1'b0; drive(1, 0, 0, 0, 0, 1);
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, 32'h0);
    tick(); drive(1, 1, 32'h0020a1b3, 0, 0, 1);
    check("s1_addr", imem_req_addr, 32'h4);
    check("s1_iv", instr_valid, 0);
    tick(); drive(1, 1, 32'h00000013, 0, 0, 1);
    check("s2_addr", imem_req_addr, 32'h8);
    check("s2_iv", instr_valid, 1);
    check("s2_instr", instr, 32'h0020a1b3);
    check("s2_pc", instr_pc, 32'h0);
    tick(); drive(0, 1, 32'h00000000, 0, 0, 1);
    check("s3_instr", instr, 32'h00000013);
    check("s3_pc", instr_pc, 32'h4);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("s4_iv", instr_valid, 1);
    check("s4_instr", instr, 32'h0);
    check("s4_pc", instr_pc, 32'h8);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("s5_iv", instr_valid, 0);
    check("s5_pc", instr_pc, 32'h0);

    // Backpressure: instr_ready low for 10 cycles after a fresh reset
    tick(); rst = 1'b1; drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) rst = 1'b0;
      d = 32'hA000_0000 | 32'((i - 1) * 4);
      drive(1, (i >= 1 && i <= 4), d, 0, 0, 0);
      check("bp_req_valid", imem_req_valid, (i < 4));
      if (i < 4) check("bp_req_addr", imem_req_addr, 32'(i * 4));
      check("bp_iv", instr_valid, (i >= 2));
    end
    check("bp_head_instr", instr, 32'hA000_0000);

    // Drain in order; requests resume at 0x10
    tick(); drive(1, 0, 0, 0, 0, 1);
    check("d0_req_valid", imem_req_valid, 0);
    check("d0_instr", instr, 32'hA000_0000);
    check("d0_pc", instr_pc, 32'h0);
    tick(); drive(1, 0, 0, 0, 0, 1);
    check("d1_req_valid", imem_req_valid, 1);
    check("d1_req_addr", imem_req_addr, 32'h10);
    check("d1_instr", instr, 32'hA000_0004);
    tick(); drive(0, 1, 32'hA000_0010, 0, 0, 1);
    check("d2_instr", instr, 32'hA000_0008);
    check("d2_pc", instr_pc, 32'h8);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("d3_instr", instr, 32'hA000_000C);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("d4_instr", instr, 32'hA000_0010);
    check("d4_pc", instr_pc, 32'h10);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("d5_iv", instr_valid, 0);
    check("d5_req_addr", imem_req_addr, 32'h14);

    // Redirect with two outstanding, 3-cycle memory
    tick(); drive(1, 0, 0, 0, 0, 1);
    check("r0_req_addr", imem_req_addr, 32'h14);
    tick(); drive(1, 0, 0, 0, 0, 1);
    check("r1_req_addr", imem_req_addr, 32'h18);
    tick(); drive(0, 0, 0, 1, 32'h103, 1);
    check("r2_req_valid", imem_req_valid, 0);
    tick(); drive(1, 1, 32'hDEAD_0014, 0, 0, 1);
    check("r3_req_valid", imem_req_valid, 1);
    check("r3_req_addr", imem_req_addr, 32'h100);
    check("r3_iv", instr_valid, 0);
    tick(); drive(0, 1, 32'hDEAD_0018, 0, 0, 1);
    check("r4_iv", instr_valid, 0);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("r5_iv", instr_valid, 0);
    tick(); drive(0, 1, 32'h0050_0093, 0, 0, 1);
    check("r6_iv", instr_valid, 0);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("r7_iv", instr_valid, 1);
    check("r7_instr", instr, 32'h0050_0093);
    check("r7_pc", instr_pc, 32'h100);
    check("r7_req_addr", imem_req_addr, 32'h104);

    // Redirect, pop and response in the same cycle
    tick(); drive(1, 0, 0, 0, 0, 0);
    check("c0_req_addr", imem_req_addr, 32'h104);
    tick(); drive(1, 1, 32'h1111_1111, 0, 0, 0);
    check("c1_req_addr", imem_req_addr, 32'h108);
    tick(); drive(0, 1, 32'h2222_2222, 1, 32'h200, 1);
    check("c2_req_valid", imem_req_valid, 0);
    check("c2_iv", instr_valid, 1);
    check("c2_instr", instr, 32'h1111_1111);
    check("c2_pc", instr_pc, 32'h104);
    tick(); drive(1, 0, 0, 0, 0, 1);
    check("c3_iv", instr_valid, 0);
    check("c3_instr", instr, 32'h0);
    check("c3_req_valid", imem_req_valid, 1);
    check("c3_req_addr", imem_req_addr, 32'h200);
    tick(); drive(0, 1, 32'h3333_3333, 0, 0, 1);
    check("c4_iv", instr_valid, 0);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("c5_iv", instr_valid, 1);
    check("c5_instr", instr, 32'h3333_3333);
    check("c5_pc", instr_pc, 32'h200);

    // Reset mid-stream with two queued and two outstanding, 2-cycle memory
    tick(); drive(1, 0, 0, 0, 0, 0);
    check("m0_req_addr", imem_req_addr, 32'h204);
    tick(); drive(1, 0, 0, 0, 0, 0);
    check("m1_req_addr", imem_req_addr, 32'h208);
    tick(); drive(1, 1, 32'hE1E1_E1E1, 0, 0, 0);
    check("m2_req_addr", imem_req_addr, 32'h20C);
    tick(); drive(1, 1, 32'hE2E2_E2E2, 0, 0, 0);
    check("m3_req_addr", imem_req_addr, 32'h210);
    check("m3_iv", instr_valid, 1);
    check("m3_instr", instr, 32'hE1E1_E1E1);
    check("m3_pc", instr_pc, 32'h204);
    tick(); rst = 1'b1; drive(1, 1, 32'hE3E3_E3E3, 0, 0, 0);
    check("m4_req_valid", imem_req_valid, 0);
    check("m4_iv", instr_valid, 0);
    check("m4_instr", instr, 32'h0);
    check("m4_pc", instr_pc, 32'h0);
    tick(); rst = 1'b0; drive(0, 1, 32'hE4E4_E4E4, 0, 0, 0);
    check("m5_req_valid", imem_req_valid, 1);
    check("m5_req_addr", imem_req_addr, 32'h0);
    check("m5_iv", instr_valid, 0);
    tick(); drive(1, 0, 0, 0, 0, 0);
    check("m6_iv", instr_valid, 0);
    check("m6_req_addr", imem_req_addr, 32'h0);
    tick(); drive(0, 1, 32'h0000_0077, 0, 0, 1);
    check("m7_iv", instr_valid, 0);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("m8_iv", instr_valid, 1);
    check("m8_instr", instr, 32'h0000_0077);
    check("m8_pc", instr_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
